ins_mem_loader: RTL and testbench

//  Write side of the instruction memory: fills it with a program so the decoder can fetch it by pc.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/ins_byte_assembler.sv | 64 ++++++
 rtl/ins_mem_loader.sv | 211 +++++++++++++++++++++
 tb/tb_ins_mem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and field-layout constants for the instruction memory loader
// Purpose: loader FSM state encoding plus the default instruction word layout
//          {opcode, a_addr, b_addr, r_addr}, shared with the instruction memory
//          and the decoder.
// Ports:   none (package)
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_t;

    localparam int DEF_INS_ADDR_WIDTH = 10;
    localparam int DEF_ADDR_WIDTH     = 10;
    localparam int DEF_OPCODE_WIDTH   = 3;

    localparam int INS_WIDTH     = DEF_OPCODE_WIDTH + 3 * DEF_ADDR_WIDTH;
    localparam int BYTES_PER_INS = (INS_WIDTH + 7) / 8;

    // Number of stream bytes needed to carry a word of the given width.
    function automatic int bytes_for_width(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/ins_byte_assembler.sv
// rtl/ins_byte_assembler.sv - packs a byte stream, MSB first, into instruction words
// Purpose: shifts accepted bytes into a word-wide register and counts them;
//          word_valid pulses together with the handshake of the last byte of a
//          word, and word_data holds the complete word from the next cycle on.
//          Bits of the first byte above WORD_WIDTH shift out and are dropped.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous reset, active-high
//   clear      in   restart byte counting at the first byte of a word
//   byte_valid in   a byte is accepted this cycle
//   byte_data  in   accepted byte
//   word_valid out  this byte completes a word (combinational pulse)
//   word_data  out  assembled word
module ins_byte_assembler
    import loader_pkg::*;
#(
    parameter int WORD_WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  word_valid,
    output logic [WORD_WIDTH-1:0] word_data
);

    localparam int NBYTES = bytes_for_width(WORD_WIDTH);
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        word_valid = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            shift_d = {shift_q[WORD_WIDTH-9:0], byte_data};
            if (cnt_q == LAST_CNT) begin
                cnt_d      = '0;
                word_valid = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign word_data = shift_q;

endmodule

// File: rtl/ins_mem_loader.sv
// rtl/ins_mem_loader.sv - instruction memory loader with processor reset hold
// Purpose: receives a 16-bit count header (MSB first) followed by packed
//          instructions over a byte stream, writes each instruction at
//          consecutive addresses from 0 and releases the processor reset once
//          the whole program is in memory.
// Build option: LOADER_CHECKSUM_EN adds a trailer byte that must equal the XOR
//          of all header and instruction bytes; otherwise the load ends after
//          the last write.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      pulse to begin a load (ignored while busy)
//   s_data/s_valid/s_ready   byte stream, handshake = s_valid & s_ready
//   ins_waddr/ins_wdata/ins_we  instruction memory write port
//   busy/done/err            load status
//   proc_rstn  processor reset, active-low, released only after a good load
module ins_mem_loader
    import loader_pkg::*;
#(
    parameter int INS_ADDR_WIDTH = 10,
    parameter int ADDR_WIDTH     = 10,
    parameter int OPCODE_WIDTH   = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [7:0]                               s_data,
    input  logic                                     s_valid,
    output logic                                     s_ready,
    output logic [INS_ADDR_WIDTH-1:0]                ins_waddr,
    output logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]     ins_wdata,
    output logic                                     ins_we,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err,
    output logic                                     proc_rstn
);

    localparam int INS_W = OPCODE_WIDTH + 3 * ADDR_WIDTH;
    // A program may fill the whole memory, so the largest legal count is 2**INS_ADDR_WIDTH.
    localparam logic [32:0] MAX_N = 33'd1 << INS_ADDR_WIDTH;

    loader_state_t state_q, state_d;

    logic                      hdr_cnt_q, hdr_cnt_d;
    logic [7:0]                hdr_hi_q, hdr_hi_d;
    logic [INS_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [INS_ADDR_WIDTH-1:0] last_q, last_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                csum_q, csum_d;
`endif

    logic             hs;
    logic             start_accept;
    logic [15:0]      hdr_n;
    logic             hdr_done;
    logic             n_zero;
    logic             n_too_big;
    logic             last_write;
    logic             asm_valid;
    logic             word_valid;
    logic [INS_W-1:0] word_data;

    assign hs           = s_valid & s_ready;
    assign start_accept = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));
    assign hdr_n        = {hdr_hi_q, s_data};
    assign hdr_done     = hs & (state_q == ST_HDR) & hdr_cnt_q;
    assign n_zero       = (hdr_n == 16'd0);
    assign n_too_big    = ({17'd0, hdr_n} > MAX_N);
    // last_q holds N-1; for N = 2**INS_ADDR_WIDTH that is all ones and idx wraps only after it.
    assign last_write   = (idx_q == last_q);
    assign asm_valid    = hs & (state_q == ST_DATA);

    ins_byte_assembler #(
        .WORD_WIDTH (INS_W)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_accept),
        .byte_valid (asm_valid),
        .byte_data  (s_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (hdr_done) begin
                    if (n_zero) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else if (n_too_big) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_write) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (hs) state_d = (s_data == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        s_ready   = 1'b0;
        ins_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        proc_rstn = 1'b0;
        case (state_q)
            ST_HDR:   begin s_ready = 1'b1; busy = 1'b1; end
            ST_DATA:  begin s_ready = 1'b1; busy = 1'b1; end
            ST_WRITE: begin ins_we  = 1'b1; busy = 1'b1; end
            ST_CSUM:  begin s_ready = 1'b1; busy = 1'b1; end
            ST_DONE:  begin done    = 1'b1; proc_rstn = 1'b1; end
            ST_ERR:   begin err     = 1'b1; end
            default:  ;
        endcase
    end

    assign ins_waddr = idx_q;
    assign ins_wdata = word_data;

    // ---------------- counters and header capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_cnt_q <= 1'b0;
            hdr_hi_q  <= '0;
            idx_q     <= '0;
            last_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            hdr_cnt_q <= hdr_cnt_d;
            hdr_hi_q  <= hdr_hi_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    always_comb begin
        hdr_cnt_d = hdr_cnt_q;
        hdr_hi_d  = hdr_hi_q;
        idx_d     = idx_q;
        last_d    = last_q;
        if (start_accept) begin
            hdr_cnt_d = 1'b0;
            idx_d     = '0;
        end else begin
            if (hs && (state_q == ST_HDR)) begin
                hdr_cnt_d = ~hdr_cnt_q;
                if (!hdr_cnt_q) hdr_hi_d = s_data;
            end
            if (hdr_done) last_d = INS_ADDR_WIDTH'(hdr_n - 16'd1);
            if (state_q == ST_WRITE) idx_d = idx_q + 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_comb begin
        csum_d = csum_q;
        if (start_accept) begin
            csum_d = '0;
        end else if (hs && ((state_q == ST_HDR) || (state_q == ST_DATA))) begin
            csum_d = csum_q ^ s_data;
        end
    end
`endif

endmodule

// File: tb/tb_ins_mem_loader.sv
// tb/tb_ins_mem_loader.sv - scoreboard bench for ins_mem_loader
module tb_ins_mem_loader;

    localparam int IAW = 10;
    localparam int AW  = 10;
    localparam int OW  = 3;
    localparam int IW  = OW + 3 * AW;
    localparam int NB  = (IW + 7) / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [7:0]     s_data = 8'd0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [IAW-1:0] ins_waddr;
    logic [IW-1:0]  ins_wdata;
    logic           ins_we;
    logic           busy;
    logic           done;
    logic           err;
    logic           proc_rstn;

    ins_mem_loader #(
        .INS_ADDR_WIDTH (IAW),
        .ADDR_WIDTH     (AW),
        .OPCODE_WIDTH   (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .ins_waddr (ins_waddr),
        .ins_wdata (ins_wdata),
        .ins_we    (ins_we),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .proc_rstn (proc_rstn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IAW-1:0] addr;
        logic [IW-1:0]  data;
    } wr_t;

    int            total = 0;
    int            bad   = 0;
    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [IW-1:0] prog[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Byte k (0 = first sent) of an instruction word, zero-extended to NB bytes.
    function automatic logic [7:0] ins_byte(input logic [IW-1:0] w, input int k);
        logic [8*NB-1:0] wide;
        wide = (8*NB)'(w);
        return wide[8*(NB-1-k) +: 8];
    endfunction

    function automatic logic [IW-1:0] rand_word();
        return IW'({$urandom(), $urandom()});
    endfunction

    // Monitor: every write the DUT makes must be the next one the model expects.
    always @(negedge clk) begin
        if (ins_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ins_waddr, ins_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(ins_waddr), 64'(mon_e.addr));
                check("wr_data", 64'(ins_wdata), 64'(mon_e.data));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int   cnt;
        logic rdy;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_data  = b;
        s_valid = 1'b1;
        cnt     = 0;
        do begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            cnt++;
        end while (!rdy && cnt < 100);
        #1;
        s_valid = 1'b0;
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: got s_ready=0 for %0d cycles expected 1", cnt);
            finish_now();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"},   64'(s_ready),   64'd0);
        check({tag, "_ins_we"},    64'(ins_we),    64'd0);
        check({tag, "_ins_waddr"}, 64'(ins_waddr), 64'd0);
        check({tag, "_ins_wdata"}, 64'(ins_wdata), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_err"},       64'(err),       64'd0);
        check({tag, "_proc_rstn"}, 64'(proc_rstn), 64'd0);
    endtask

    // One load: header n_hdr, the first n_send words of prog, random gaps up to
    // gap_max. flip corrupts the trailer (checksum build). abort_at > 0 asserts
    // rst after that many instruction bytes.
    task automatic run_load(input int n_hdr, input int n_send, input int gap_max,
                            input bit flip, input bit exp_err, input int abort_at);
        logic [15:0] n16;
        logic [7:0]  cs;
        logic [7:0]  b;
        wr_t         e;
        int          bi;
        int          cyc;
        n16 = n_hdr[15:0];
        pulse_start();
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_after_start", 64'(done), 64'd0);
        check("err_after_start",  64'(err),  64'd0);
        check("prstn_after_start", 64'(proc_rstn), 64'd0);
        for (int i = 0; i < n_send; i++) begin
            e.addr = IAW'(i);
            e.data = prog[i];
            exp_q.push_back(e);
        end
        cs = n16[15:8] ^ n16[7:0];
        send_byte(n16[15:8], 0);
        send_byte(n16[7:0], 0);
        bi = 0;
        for (int i = 0; i < n_send; i++) begin
            for (int k = 0; k < NB; k++) begin
                if (gap_max > 0 && i == 1 && k == 2) begin
                    pulse_start();
                    check("busy_start_ignored", 64'(busy), 64'd1);
                end
                b  = ins_byte(prog[i], k);
                cs = cs ^ b;
                send_byte(b, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
                bi++;
                if (bi == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check_reset_values("abort");
                    exp_q.delete();
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    return;
                end
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (n_hdr <= (1 << IAW)) send_byte(flip ? (cs ^ 8'h01) : cs, 0);
`else
        if (flip) $display("note: trailer corruption has no effect without a checksum");
`endif
        cyc = 0;
        while (!done && !err && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("end_latency_ok", 64'(cyc <= 2), 64'd1);
        check("end_done",  64'(done),      64'(!exp_err));
        check("end_err",   64'(err),       64'(exp_err));
        check("end_prstn", 64'(proc_rstn), 64'(!exp_err));
        check("end_busy",  64'(busy),      64'd0);
        check("end_pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        total++;
        bad++;
        $display("FAIL watchdog: got no end of test expected finish");
        finish_now();
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("idle");

        // Two fixed instructions.
        prog.delete();
        prog.push_back({3'b000, 10'd1, 10'd2, 10'd3});
        prog.push_back({3'b101, 10'd0, 10'd7, 10'd9});
        run_load(2, 2, 0, 1'b0, 1'b0, 0);

        // Empty program.
        run_load(0, 0, 0, 1'b0, 1'b0, 0);

        // Count beyond memory size, then a good load clears err.
        run_load(1025, 0, 0, 1'b0, 1'b1, 0);
        prog.delete();
        prog.push_back(rand_word());
        run_load(1, 1, 0, 1'b0, 1'b0, 0);

        // Same program with and without stream gaps.
        prog.delete();
        for (int i = 0; i < 6; i++) prog.push_back(rand_word());
        run_load(6, 6, 0, 1'b0, 1'b0, 0);
        run_load(6, 6, 7, 1'b0, 1'b0, 0);

        // Reset after the third byte of the second instruction, then reload.
        prog.delete();
        for (int i = 0; i < 3; i++) prog.push_back(rand_word());
        run_load(3, 3, 0, 1'b0, 1'b0, NB + 3);
        run_load(3, 3, 2, 1'b0, 1'b0, 0);

        // Random programs.
        for (int t = 0; t < 4; t++) begin
            n = int'($urandom_range(1, 12));
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back(rand_word());
            run_load(n, n, 3, 1'b0, 1'b0, 0);
        end

`ifdef LOADER_CHECKSUM_EN
        // Corrupted trailer: writes still happen, load fails.
        prog.delete();
        for (int i = 0; i < 3; i++) prog.push_back(rand_word());
        run_load(3, 3, 0, 1'b1, 1'b1, 0);
`endif

        // Full memory: index wraps only on the final write.
        prog.delete();
        for (int i = 0; i < (1 << IAW); i++) prog.push_back(rand_word());
        run_load(1 << IAW, 1 << IAW, 0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("full_no_extra_write", 64'(exp_q.size()), 64'd0);
        check("full_done_held", 64'(done), 64'd1);

        finish_now();
    end

endmodule
